toy_proc_run_ctrl: RTL and testbench

Reset-release and run-control block that sits between the board clock/reset and the toy processor core. It holds the core in reset for a programmable time and releases parametrised reset channels in a staggered order. It then gates the core's clock enable in run, single-step or halt modes, and stops the core after a programmable cycle limit. It is the synthesizable successor of the bench's fixed hold-then-release reset.

---
 rtl/toy_proc_pkg.sv | 28 ++
 rtl/rst_sync.sv | 20 ++
 rtl/toy_proc_run_ctrl.sv | 132 +++++++++++++
 tb/tb_toy_proc_run_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_proc_pkg.sv
// Shared types for the toy processor run-control slice: FSM state and mode encodings.
package toy_proc_pkg;

    typedef enum logic [2:0] {
        ST_HOLD = 3'd0,
        ST_REL  = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_HALT = 2'b10;

    // Reserved mode 2'b11 lands in HALT.
    function automatic state_t mode_to_state(input logic [1:0] mode);
        state_t st;
        case (mode)
            MODE_RUN:  st = ST_RUN;
            MODE_STEP: st = ST_STEP;
            default:   st = ST_HALT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the second rising clk edge.
module rst_sync (
    input  logic clk,
    input  logic rst_n_async,
    output logic rst_n_sync
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n_async) begin
        if (!rst_n_async) begin
            meta       <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            meta       <= 1'b1;
            rst_n_sync <= meta;
        end
    end

endmodule

// File: rtl/toy_proc_run_ctrl.sv
// Reset-release sequencer and run/step/halt clock-enable controller for the toy core,
// with an enabled-cycle budget that parks the core in DONE.
module toy_proc_run_ctrl
    import toy_proc_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned NUM_CHANNELS    = 2,
    parameter int unsigned STAGGER         = 4,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode_i,
    input  logic                    step_req,
    input  logic                    soft_rst_req,
    input  logic [CNT_W-1:0]        cycle_limit,
    output logic [NUM_CHANNELS-1:0] core_rst_n,
    output logic                    core_en,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic                    done,
    output logic [2:0]              state_o
);

    localparam int unsigned MAX_PER = (RST_HOLD_CYCLES > STAGGER) ? RST_HOLD_CYCLES : STAGGER;
    localparam int unsigned TMR_W   = (MAX_PER > 1) ? $clog2(MAX_PER) : 1;
    localparam int unsigned CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] STAG_LD = TMR_W'(STAGGER - 1);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CHANNELS - 1);

    logic                    rst_n_int;
    state_t                  state, state_d;
    logic [TMR_W-1:0]        tmr, tmr_d;
    logic [CH_W-1:0]         ch_idx, ch_idx_d;
    logic [CNT_W-1:0]        cnt_inc, cycle_cnt_d;
    logic                    step_pend, step_pend_d;
    logic                    core_en_d, done_d, limit_hit;
    logic [NUM_CHANNELS-1:0] core_rst_n_d;

    rst_sync u_rst_sync (
        .clk         (clk),
        .rst_n_async (rst),
        .rst_n_sync  (rst_n_int)
    );

    assign cnt_inc   = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    // >= so that a limit lowered below the count still stops on the next enabled cycle.
    assign limit_hit = core_en && (cycle_limit != '0) && (cnt_inc >= cycle_limit);
    assign state_o   = 3'(state);

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) state <= ST_HOLD;
        else            state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (soft_rst_req) begin
            state_d = ST_HOLD;
        end else begin
            case (state)
                ST_HOLD: if (tmr == '0) state_d = ST_REL;
                ST_REL:  if (ch_idx == LAST_CH) state_d = mode_to_state(mode_i);
                ST_RUN, ST_STEP, ST_HALT:
                    state_d = limit_hit ? ST_DONE : mode_to_state(mode_i);
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_HOLD;
            endcase
        end
    end

    // Next values of the shared timer, channel index, counter and the registered outputs.
    always_comb begin
        tmr_d        = tmr;
        ch_idx_d     = ch_idx;
        cycle_cnt_d  = cycle_cnt;
        step_pend_d  = 1'b0;
        core_en_d    = 1'b0;
        done_d       = 1'b0;
        core_rst_n_d = '0;
        if (soft_rst_req) begin
            tmr_d       = HOLD_LD;
            ch_idx_d    = '0;
            cycle_cnt_d = '0;
        end else begin
            if (core_en) cycle_cnt_d = cnt_inc;
            case (state)
                ST_HOLD: tmr_d = (tmr == '0) ? STAG_LD : tmr - TMR_W'(1);
                ST_REL: begin
                    if (ch_idx != LAST_CH) begin
                        if (tmr == '0) begin
                            ch_idx_d = ch_idx + CH_W'(1);
                            tmr_d    = STAG_LD;
                        end else begin
                            tmr_d = tmr - TMR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
            // A request is only taken when no step cycle is pending or running.
            step_pend_d = (state == ST_STEP) && (state_d == ST_STEP) && step_req
                          && !step_pend && !core_en;
        end
        core_en_d = (state_d == ST_RUN) || ((state_d == ST_STEP) && step_pend);
        done_d    = (state_d == ST_DONE);
        for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
            core_rst_n_d[k] = (state_d != ST_HOLD) && (CH_W'(k) <= ch_idx_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            tmr        <= HOLD_LD;
            ch_idx     <= '0;
            cycle_cnt  <= '0;
            step_pend  <= 1'b0;
            core_en    <= 1'b0;
            done       <= 1'b0;
            core_rst_n <= '0;
        end else begin
            tmr        <= tmr_d;
            ch_idx     <= ch_idx_d;
            cycle_cnt  <= cycle_cnt_d;
            step_pend  <= step_pend_d;
            core_en    <= core_en_d;
            done       <= done_d;
            core_rst_n <= core_rst_n_d;
        end
    end

endmodule

// File: tb/tb_toy_proc_run_ctrl.sv
// Self-checking bench for toy_proc_run_ctrl: timeline-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_toy_proc_run_ctrl;

    localparam int HOLD = 16;
    localparam int NCH  = 2;
    localparam int STG  = 4;
    localparam int ACT  = HOLD + (NCH - 1) * STG + 1;
    localparam int PH_RUN  = 2;
    localparam int PH_STEP = 3;
    localparam int PH_HALT = 4;
    localparam int PH_DONE = 5;

    logic           clk;
    logic           rst;
    logic [1:0]     mode;
    logic           step_req;
    logic           soft_rst_req;
    logic [7:0]     cycle_limit;
    logic [NCH-1:0] core_rst_n;
    logic           core_en;
    logic [7:0]     cycle_cnt;
    logic           done;
    logic [2:0]     state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int waited;
    int n_en;

    toy_proc_run_ctrl #(
        .RST_HOLD_CYCLES (HOLD),
        .NUM_CHANNELS    (NCH),
        .STAGGER         (STG),
        .CNT_W           (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_i       (mode),
        .step_req     (step_req),
        .soft_rst_req (soft_rst_req),
        .cycle_limit  (cycle_limit),
        .core_rst_n   (core_rst_n),
        .core_en      (core_en),
        .cycle_cnt    (cycle_cnt),
        .done         (done),
        .state_o      (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: t = active edges since (soft) reset, phase/enable/count after release.
    typedef struct packed {
        int         t;
        int         sync;
        int         ph;
        logic       en;
        logic [7:0] cnt;
        logic       pend;
    } mdl_t;

    mdl_t m;

    function automatic int ph_of(input logic [1:0] md);
        return (md == 2'b00) ? PH_RUN : (md == 2'b01) ? PH_STEP : PH_HALT;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t c, input logic [1:0] md, input logic sr,
                                      input logic so, input logic [7:0] lim);
        mdl_t n;
        int   np;
        n = c;
        if (c.sync < 2) begin
            n.sync = c.sync + 1;
            return n;
        end
        if (so) begin
            n = '0;
            n.sync = 2;
            return n;
        end
        if (c.t < ACT) begin
            n.t = c.t + 1;
            if (n.t == ACT) begin
                n.ph = ph_of(md);
                n.en = (n.ph == PH_RUN);
            end
            return n;
        end
        if (c.ph == PH_DONE) return n;
        if (c.en) n.cnt = (c.cnt == 8'hFF) ? c.cnt : c.cnt + 8'd1;
        if (c.en && lim != 8'd0 && n.cnt >= lim) begin
            n.ph   = PH_DONE;
            n.en   = 1'b0;
            n.pend = 1'b0;
            return n;
        end
        np     = ph_of(md);
        n.pend = (c.ph == PH_STEP) && (np == PH_STEP) && sr && !c.pend && !c.en;
        n.en   = (np == PH_RUN) || ((np == PH_STEP) && (c.ph == PH_STEP) && c.pend);
        n.ph   = np;
        return n;
    endfunction

    function automatic logic [NCH-1:0] exp_rst_n(input int t);
        logic [NCH-1:0] r;
        for (int k = 0; k < NCH; k++) r[k] = (t >= HOLD + k * STG);
        return r;
    endfunction

    function automatic logic [2:0] exp_state(input mdl_t c);
        if (c.t < HOLD) return 3'd0;
        if (c.t < ACT)  return 3'd1;
        return 3'(c.ph);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else      m <= mdl_next(m, mode, step_req, soft_rst_req, cycle_limit);
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_core_rst_n", 32'(core_rst_n), 32'(exp_rst_n(m.t)));
            chk("m_core_en",    32'(core_en),    32'(m.en));
            chk("m_cycle_cnt",  32'(cycle_cnt),  32'(m.cnt));
            chk("m_done",       32'(done),       32'(m.ph == PH_DONE));
            chk("m_state",      32'(state_o),    32'(exp_state(m)));
        end
    end

    initial begin
        rst = 1'b0; mode = 2'b00; step_req = 1'b0; soft_rst_req = 1'b0; cycle_limit = 8'd0;
        repeat (4) @(negedge clk);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_core_en",    32'(core_en),    32'd0);
        chk("rst_cnt",        32'(cycle_cnt),  32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_state",      32'(state_o),    32'd0);

        // Release: ch0 at edge 18, ch1 at edge 22, RUN at edge 23.
        rst = 1'b1;
        repeat (17) @(negedge clk);
        chk("hold_all_reset", 32'(core_rst_n), 32'd0);
        @(negedge clk);
        chk("ch0_release", 32'(core_rst_n), 32'd1);
        chk("rel_state",   32'(state_o),    32'd1);
        repeat (3) @(negedge clk);
        chk("ch1_still_held", 32'(core_rst_n), 32'd1);
        @(negedge clk);
        chk("ch1_release", 32'(core_rst_n), 32'd3);
        @(negedge clk);
        chk("run_entry_en",    32'(core_en), 32'd1);
        chk("run_entry_state", 32'(state_o), 32'd2);
        repeat (5) @(negedge clk);
        chk("run_cnt5", 32'(cycle_cnt), 32'd5);

        // Step mode: three requests, the first held two cycles (second sample ignored).
        mode = 2'b01;
        @(negedge clk);
        chk("step_state", 32'(state_o),   32'd3);
        chk("step_en0",   32'(core_en),   32'd0);
        chk("step_cnt6",  32'(cycle_cnt), 32'd6);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            @(negedge clk);
            chk("step_req_edge", 32'(core_en), 32'd0);
            step_req = (i == 0);
            @(negedge clk);
            chk("step_pulse", 32'(core_en), 32'd1);
            step_req = 1'b0;
            @(negedge clk);
            chk("step_pulse_end", 32'(core_en), 32'd0);
            @(negedge clk);
            chk("step_no_extra", 32'(core_en), 32'd0);
            @(negedge clk);
        end
        chk("step_cnt9", 32'(cycle_cnt), 32'd9);

        // step_req together with halt: HALT wins, no pulse.
        mode = 2'b10; step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        chk("halt_state", 32'(state_o), 32'd4);
        chk("halt_en",    32'(core_en), 32'd0);
        @(negedge clk);
        chk("halt_no_pulse", 32'(core_en),   32'd0);
        chk("halt_cnt9",     32'(cycle_cnt), 32'd9);

        // Limit of 10 from a fresh soft-reset sequence.
        mode = 2'b00; cycle_limit = 8'd10; soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        chk("soft_rst_n", 32'(core_rst_n), 32'd0);
        chk("soft_cnt",   32'(cycle_cnt),  32'd0);
        chk("soft_state", 32'(state_o),    32'd0);
        waited = 0; n_en = 0;
        while (!done && waited < 100) begin
            @(negedge clk);
            waited++;
            if (core_en) n_en++;
        end
        chk("limit_latency",   32'(waited),    32'd31);
        chk("limit_en_cycles", 32'(n_en),      32'd10);
        chk("limit_done",      32'(done),      32'd1);
        chk("limit_state",     32'(state_o),   32'd5);
        chk("limit_cnt",       32'(cycle_cnt), 32'd10);
        for (int i = 0; i < 4; i++) begin
            mode = 2'(i);
            @(negedge clk);
            chk("done_sticky_state", 32'(state_o),   32'd5);
            chk("done_sticky_cnt",   32'(cycle_cnt), 32'd10);
            chk("done_sticky_en",    32'(core_en),   32'd0);
        end

        // Soft reset mid-run at count 7.
        mode = 2'b00; cycle_limit = 8'd0; soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        waited = 0;
        while (cycle_cnt != 8'd7 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("cnt7_latency", 32'(waited), 32'd28);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        chk("midrun_soft_rst_n", 32'(core_rst_n), 32'd0);
        chk("midrun_soft_cnt",   32'(cycle_cnt),  32'd0);
        chk("midrun_soft_en",    32'(core_en),    32'd0);
        chk("midrun_soft_done",  32'(done),       32'd0);
        repeat (16) @(negedge clk);
        chk("resoft_ch0", 32'(core_rst_n), 32'd1);
        repeat (5) @(negedge clk);
        chk("resoft_run", 32'(state_o), 32'd2);

        // Lowering the limit below the count stops on the next enabled cycle.
        repeat (20) @(negedge clk);
        chk("pre_lower_cnt", 32'(cycle_cnt), 32'd20);
        cycle_limit = 8'd5;
        @(negedge clk);
        chk("lower_state", 32'(state_o),   32'd5);
        chk("lower_done",  32'(done),      32'd1);
        chk("lower_cnt",   32'(cycle_cnt), 32'd21);

        // Soft reset in the same cycle the limit would be reached.
        cycle_limit = 8'd10; soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        waited = 0;
        while (cycle_cnt != 8'd9 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("cnt9_latency", 32'(waited), 32'd30);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        chk("soft_vs_limit_state", 32'(state_o),   32'd0);
        chk("soft_vs_limit_done",  32'(done),      32'd0);
        chk("soft_vs_limit_cnt",   32'(cycle_cnt), 32'd0);
        cycle_limit = 8'd0;
        @(negedge clk);
        chk("soft_vs_limit_done2", 32'(done), 32'd0);

        // Unlimited run: counter saturates, no DONE.
        repeat (290) @(negedge clk);
        chk("sat_cnt",   32'(cycle_cnt), 32'd255);
        chk("sat_state", 32'(state_o),   32'd2);
        chk("sat_en",    32'(core_en),   32'd1);

        // Async reset asserted mid-cycle during RUN.
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_n", 32'(core_rst_n), 32'd0);
        chk("async_en",    32'(core_en),    32'd0);
        chk("async_cnt",   32'(cycle_cnt),  32'd0);
        chk("async_state", 32'(state_o),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (23) @(negedge clk);
        chk("rerelease_state", 32'(state_o), 32'd2);
        chk("rerelease_en",    32'(core_en), 32'd1);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
